// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-clearing sweep, then round-robin valid/ready arbitration of
// two writers into a 32x32 register file, with writes to $zero suppressed.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr_req,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_writeEnable,
    output logic [ADDR_W-1:0] rf_writeAddress,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              init_done,
    output logic              wr_pending
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic we_q, we_d, prio_q, prio_d, init_q, init_d, grant_ok;
    // prio_q: 0 favours A, 1 favours B when both are valid
    assign grant_ok = state_q == RUN && !clr_req;
    assign a_ready = grant_ok && a_valid && (!b_valid || !prio_q);
    assign b_ready = grant_ok && b_valid && (!a_valid || prio_q);
    assign rf_writeEnable = we_q;
    assign rf_writeAddress = addr_q;
    assign rf_writeData = data_q;
    assign init_done = init_q;
    assign wr_pending = we_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        we_d = 1'b0;
        prio_d = prio_q;
        init_d = init_q;
        if (state_q == CLEAR) begin
            we_d = 1'b1;
            addr_d = cnt_q;
            data_d = '0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = RUN;
                cnt_d = '0;
                init_d = 1'b1;
            end
        end else if (clr_req) begin
            state_d = CLEAR;
            cnt_d = '0;
            init_d = 1'b0;
        end else if (a_ready || b_ready) begin
            addr_d = a_ready ? a_addr : b_addr;
            data_d = a_ready ? a_data : b_data;
            // a write to $zero is acknowledged but never reaches the register file
            we_d = addr_d != '0;
            prio_d = a_ready;
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q <= 1'b0;
            prio_q <= 1'b0;
            init_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q <= we_d;
            prio_q <= prio_d;
            init_q <= init_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios for the clear sweep, arbitration and $zero suppression.
module tb_regfile_write_arbiter;
    logic        CLK = 1'b0, RST_N = 1'b0, clr_req = 1'b0, a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_writeEnable, init_done, wr_pending;
    logic [4:0]  rf_writeAddress;
    logic [31:0] rf_writeData;
    logic [31:0] rf_model [32];
    int tests = 0, fails = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .clr_req(clr_req),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_writeEnable(rf_writeEnable), .rf_writeAddress(rf_writeAddress),
        .rf_writeData(rf_writeData), .init_done(init_done), .wr_pending(wr_pending)
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < 32; i++) rf_model[i] = 32'hA5A5_A5A5;
    always @(posedge CLK) if (rf_writeEnable) rf_model[rf_writeAddress] <= rf_writeData;

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (rf_writeEnable !== 1'b0 || rf_writeAddress !== 5'd0 || rf_writeData !== 32'd0 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h init=%b, required 0 0 0 0", rf_writeEnable, rf_writeAddress, rf_writeData, init_done);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge CLK);
            #1;
            tests++;
            if (rf_writeEnable !== 1'b1 || wr_pending !== 1'b1 || rf_writeAddress !== 5'(i) || rf_writeData !== 32'd0 || init_done !== (i == 31)) begin
                fails++;
                $display("FAIL reset_sweep[%0d]: we=%b pend=%b addr=%0d data=%h init=%b, required 1 1 %0d 0 %b", i, rf_writeEnable, wr_pending, rf_writeAddress, rf_writeData, init_done, i, i == 31);
            end
        end
        @(posedge CLK);
        #1;
        tests++;
        if (rf_writeEnable !== 1'b0 || init_done !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: we=%b init=%b, required 0 1", rf_writeEnable, init_done);
        end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (rf_model[i] !== 32'd0) begin
                fails++;
                $display("FAIL reset_rf_zero[%0d]: got %h, required 0", i, rf_model[i]);
            end
        end
    endtask

    task automatic test_single_a;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_a_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        tests++;
        if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'd5 || rf_writeData !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_a_write: we=%b addr=%0d data=%h, required 1 5 deadbeef", rf_writeEnable, rf_writeAddress, rf_writeData);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (rf_model[5] !== 32'hDEADBEEF || rf_writeEnable !== 1'b0 || rf_writeAddress !== 5'd5 || rf_writeData !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_a_commit: r5=%h we=%b addr=%0d data=%h, required deadbeef 0 5 deadbeef", rf_model[5], rf_writeEnable, rf_writeAddress, rf_writeData);
        end
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_after_a: a_ready=%b b_ready=%b, required 0 1", a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_zero_write;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        #1;
        tests++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_ready: a_ready=%b b_ready=%b, required 0 1", a_ready, b_ready);
        end
        @(posedge CLK);
        #1;
        b_valid = 1'b0;
        tests++;
        if (rf_writeEnable !== 1'b0) begin
            fails++;
            $display("FAIL zero_suppress: we=%b, required 0", rf_writeEnable);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (rf_model[0] !== 32'd0) begin
            fails++;
            $display("FAIL zero_r0: got %h, required 0", rf_model[0]);
        end
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_after_b: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_data [4];
        exp_data[0] = 32'd1; exp_data[1] = 32'd10; exp_data[2] = 32'd2; exp_data[3] = 32'd20;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd1;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'd10;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL b2b_grant[%0d]: a_ready=%b b_ready=%b, required %b %b", k, a_ready, b_ready, k % 2 == 0, k % 2 == 1);
            end
            @(posedge CLK);
            #1;
            tests++;
            if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'd3 || rf_writeData !== exp_data[k]) begin
                fails++;
                $display("FAIL b2b_write[%0d]: we=%b addr=%0d data=%0d, required 1 3 %0d", k, rf_writeEnable, rf_writeAddress, rf_writeData, exp_data[k]);
            end
            if (k % 2 == 0) a_data = 32'd2;
            else b_data = 32'd20;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if (rf_model[3] !== 32'd20) begin
            fails++;
            $display("FAIL b2b_final: r3=%0d, required 20", rf_model[3]);
        end
    endtask

    task automatic test_clear;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd77; clr_req = 1'b1;
        #1;
        tests++;
        if (a_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_block: a_ready=%b, required 0", a_ready);
        end
        @(posedge CLK);
        #1;
        clr_req = 1'b0;
        tests++;
        if (init_done !== 1'b0 || rf_writeEnable !== 1'b0) begin
            fails++;
            $display("FAIL clr_enter: init=%b we=%b, required 0 0", init_done, rf_writeEnable);
        end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (a_ready !== 1'b0) begin
                fails++;
                $display("FAIL clr_hold[%0d]: a_ready=%b, required 0", i, a_ready);
            end
            @(posedge CLK);
            #1;
            tests++;
            if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'(i) || rf_writeData !== 32'd0 || init_done !== (i == 31)) begin
                fails++;
                $display("FAIL clr_sweep[%0d]: we=%b addr=%0d data=%h init=%b, required 1 %0d 0 %b", i, rf_writeEnable, rf_writeAddress, rf_writeData, init_done, i, i == 31);
            end
        end
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL clr_resume: a_ready=%b, required 1", a_ready);
        end
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        tests++;
        if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'd7 || rf_writeData !== 32'd77 || rf_model[3] !== 32'd0 || rf_model[5] !== 32'd0) begin
            fails++;
            $display("FAIL clr_after: we=%b addr=%0d data=%0d r3=%h r5=%h, required 1 7 77 0 0", rf_writeEnable, rf_writeAddress, rf_writeData, rf_model[3], rf_model[5]);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid_sweep;
        clr_req = 1'b1;
        @(posedge CLK);
        #1;
        clr_req = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        tests++;
        if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'd9) begin
            fails++;
            $display("FAIL mid_pre: we=%b addr=%0d, required 1 9", rf_writeEnable, rf_writeAddress);
        end
        RST_N = 1'b0;
        #1;
        tests++;
        if (rf_writeEnable !== 1'b0 || rf_writeAddress !== 5'd0 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: we=%b addr=%0d init=%b, required 0 0 0", rf_writeEnable, rf_writeAddress, init_done);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge CLK);
            #1;
            tests++;
            if (rf_writeEnable !== 1'b1 || rf_writeAddress !== 5'(i) || init_done !== (i == 31)) begin
                fails++;
                $display("FAIL mid_sweep[%0d]: we=%b addr=%0d init=%b, required 1 %0d %b", i, rf_writeEnable, rf_writeAddress, init_done, i, i == 31);
            end
        end
        @(posedge CLK);
        #1;
        tests++;
        if (rf_writeEnable !== 1'b0 || init_done !== 1'b1 || rf_model[7] !== 32'd0) begin
            fails++;
            $display("FAIL mid_done: we=%b init=%b r7=%h, required 0 1 0", rf_writeEnable, init_done, rf_model[7]);
        end
    endtask

    initial begin
        test_reset;
        test_single_a;
        test_zero_write;
        test_back_to_back;
        test_clear;
        test_reset_mid_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
